// File: rtl/vga_console_if.sv
// Byte-stream input and text-buffer write port of the VGA console controller.
// The slave modport is the controller side; the master modport is the byte source / observer.
interface vga_console_if #(
   parameter int COLS = 160,
   parameter int ROWS = 128
);
   localparam int ADDR_WIDTH = $clog2(COLS*ROWS);
   localparam int CW         = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW         = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [7:0]            wr_data;
   logic                  busy;
   logic [CW-1:0]         cursor_col;
   logic [RW-1:0]         cursor_row;

   modport master (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data, busy, cursor_col, cursor_row
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data, busy, cursor_col, cursor_row
   );
endinterface

// File: rtl/vga_console.sv
// Character-stream console: turns bytes into text-buffer cell writes and cursor moves,
// and sweeps the whole screen with spaces after reset and on form feed.
module vga_console #(
   parameter int COLS       = 160,
   parameter int ROWS       = 128,
   parameter int ADDR_WIDTH = $clog2(COLS*ROWS)
) (
   input  logic           clk,
   input  logic           reset,
   vga_console_if.slave   bus
);
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(COLS*ROWS-1);
   localparam logic [ADDR_WIDTH-1:0] COLS_A = ADDR_WIDTH'(COLS);
   localparam logic [CW-1:0]         LAST_C = CW'(COLS-1);
   localparam logic [RW-1:0]         LAST_R = RW'(ROWS-1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CW-1:0]         col_q;
   logic [RW-1:0]         row_q;
   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [7:0]            wr_data_q;
   logic [ADDR_WIDTH-1:0] line_base_d;

   // Start of the current line, derived from the linear address so no multiplier is needed.
   assign line_base_d = addr_q - ADDR_WIDTH'(col_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         addr_q    <= '0;
         col_q     <= '0;
         row_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 8'h00;
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            CLEAR: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= cnt_q;
               wr_data_q <= 8'h20;
               if (cnt_q == LAST_A) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + ADDR_WIDTH'(1);
               end
            end
            IDLE: if (bus.in_valid) begin
               if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= addr_q;
                  wr_data_q <= bus.in_data;
                  addr_q    <= (addr_q == LAST_A) ? '0 : addr_q + ADDR_WIDTH'(1);
                  if (col_q == LAST_C) begin
                     col_q <= '0;
                     row_q <= (row_q == LAST_R) ? '0 : row_q + RW'(1);
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
               end else begin
                  case (bus.in_data)
                     8'h0A: begin
                        col_q  <= '0;
                        row_q  <= (row_q == LAST_R) ? '0 : row_q + RW'(1);
                        addr_q <= (row_q == LAST_R) ? '0 : line_base_d + COLS_A;
                     end
                     8'h0D: begin
                        col_q  <= '0;
                        addr_q <= line_base_d;
                     end
                     8'h08: if (col_q != '0) begin
                        col_q     <= col_q - CW'(1);
                        addr_q    <= addr_q - ADDR_WIDTH'(1);
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q - ADDR_WIDTH'(1);
                        wr_data_q <= 8'h20;
                     end
                     8'h0C: begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        col_q   <= '0;
                        row_q   <= '0;
                        addr_q  <= '0;
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.busy       = (state_q == CLEAR);
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.cursor_col = col_q;
   assign bus.cursor_row = row_q;
endmodule

// File: tb/tb_vga_console.sv
// Directed bench for vga_console: a cursor model pushes expected writes at drive time,
// a negedge monitor pops and compares every write the DUT produces.
module tb_vga_console;
   localparam int COLS = 4;
   localparam int ROWS = 2;
   localparam int N    = COLS*ROWS;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vga_console_if #(.COLS(COLS), .ROWS(ROWS)) ifc ();
   vga_console #(.COLS(COLS), .ROWS(ROWS)) dut (.clk(clk), .reset(reset), .bus(ifc));

   typedef struct {int addr; int data;} wr_t;
   wr_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int m_col    = 0;
   int m_row    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input int a, input int d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic push_clear();
      for (int i = 0; i < N; i++) push_wr(i, 32'h20);
   endtask

   // Reference cursor model, addressed as row*COLS+col.
   task automatic model(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         push_wr(m_row*COLS + m_col, int'(b));
         if (m_col == COLS-1) begin
            m_col = 0;
            m_row = (m_row == ROWS-1) ? 0 : m_row + 1;
         end else m_col++;
      end else if (b == 8'h0A) begin
         m_col = 0;
         m_row = (m_row == ROWS-1) ? 0 : m_row + 1;
      end else if (b == 8'h0D) begin
         m_col = 0;
      end else if (b == 8'h08) begin
         if (m_col > 0) begin
            m_col--;
            push_wr(m_row*COLS + m_col, 32'h20);
         end
      end else if (b == 8'h0C) begin
         push_clear();
         m_col = 0;
         m_row = 0;
      end
   endtask

   // Presents b, waits for in_ready, returns after the accepting edge with in_valid still high.
   task automatic send_byte(input logic [7:0] b, output int waits);
      ifc.in_data  = b;
      ifc.in_valid = 1'b1;
      model(b);
      waits = 0;
      while (!ifc.in_ready && waits < 50) begin
         step();
         waits++;
      end
      if (!ifc.in_ready) begin
         chk("ready_timeout", ifc.in_ready, 1);
         ifc.in_valid = 1'b0;
      end else begin
         step();
      end
   endtask

   task automatic send(input logic [7:0] b);
      int w;
      send_byte(b, w);
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (exp_q.size() != 0 && k < 40) begin
         step();
         k++;
      end
      chk(tag, exp_q.size(), 0);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (!ifc.in_ready && k < 40) begin
         step();
         k++;
      end
      chk(tag, ifc.in_ready, 1);
   endtask

   always @(negedge clk) begin
      if (!reset && ifc.wr_en) begin
         if (exp_q.size() == 0) begin
            chk("spurious_wr_en", ifc.wr_en, 0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", ifc.wr_addr, e.addr);
            chk("wr_data", ifc.wr_data, e.data);
         end
      end
   end

   initial begin
      int w;
      int t;
      int k;
      reset        = 1'b1;
      ifc.in_valid = 1'b0;
      ifc.in_data  = 8'h00;
      step();
      step();
      chk("rst_wr_en", ifc.wr_en, 0);
      chk("rst_wr_addr", ifc.wr_addr, 0);
      chk("rst_wr_data", ifc.wr_data, 0);
      chk("rst_busy", ifc.busy, 1);
      chk("rst_in_ready", ifc.in_ready, 0);
      chk("rst_cursor", {ifc.cursor_row, ifc.cursor_col}, 0);

      // Reset then idle
      push_clear();
      reset = 1'b0;
      step();
      chk("clr1_busy", ifc.busy, 1);
      chk("clr1_in_ready", ifc.in_ready, 0);
      repeat (N-1) step();
      chk("clr_done_busy", ifc.busy, 0);
      chk("clr_done_in_ready", ifc.in_ready, 1);
      step();
      chk("edge9_wr_en", ifc.wr_en, 0);
      drain("drain_clear");

      // Back-to-back stream
      for (int i = 0; i < 5; i++) begin
         send_byte(8'h41 + 8'(i), w);
         chk("stream_nobubble", w, 0);
      end
      ifc.in_valid = 1'b0;
      drain("drain_stream");
      chk("stream_col", ifc.cursor_col, 1);
      chk("stream_row", ifc.cursor_row, 1);

      // Full-screen wrap
      send(8'h0C);
      ifc.in_valid = 1'b0;
      wait_idle("wrap_ff_idle");
      for (int i = 0; i < N; i++) send("x");
      send("y");
      ifc.in_valid = 1'b0;
      drain("drain_wrap");
      chk("wrap_col", ifc.cursor_col, 1);
      chk("wrap_row", ifc.cursor_row, 0);
      send(8'h0A);
      chk("lf1_row", ifc.cursor_row, 1);
      chk("lf1_col", ifc.cursor_col, 0);
      send(8'h0A);
      ifc.in_valid = 1'b0;
      chk("lf2_row", ifc.cursor_row, 0);
      step();
      drain("drain_lf");

      // Control codes
      send("A");
      send("B");
      send(8'h08);
      ifc.in_valid = 1'b0;
      drain("drain_bs");
      chk("bs_col", ifc.cursor_col, 1);
      send(8'h0D);
      chk("cr_col", ifc.cursor_col, 0);
      send(8'h08);
      send(8'h07);
      send_byte(8'h7F, w);
      ifc.in_valid = 1'b0;
      chk("ignored_consumed", w, 0);
      step();
      step();
      drain("drain_ctrl");
      chk("ctrl_col", ifc.cursor_col, 0);
      chk("ctrl_row", ifc.cursor_row, 0);

      // FF with in_valid held and next byte waiting
      send(8'h0C);
      t = cyc;
      send_byte("Z", w);
      ifc.in_valid = 1'b0;
      chk("ff_ready_low_cycles", w, N);
      chk("z_accept_edge", cyc - t, N + 1);
      drain("drain_ff");
      chk("ff_z_col", ifc.cursor_col, 1);

      // Reset mid-clear
      send(8'h0C);
      ifc.in_valid = 1'b0;
      k = 0;
      while (!(ifc.wr_en && ifc.wr_addr == 5) && k < 20) begin
         step();
         k++;
      end
      chk("midclr_addr5_seen", ifc.wr_addr, 5);
      #2 reset = 1'b1;
      #1;
      chk("async_wr_en", ifc.wr_en, 0);
      chk("async_wr_addr", ifc.wr_addr, 0);
      chk("async_busy", ifc.busy, 1);
      chk("async_in_ready", ifc.in_ready, 0);
      exp_q.delete();
      m_col = 0;
      m_row = 0;
      push_clear();
      step();
      reset = 1'b0;
      step();
      chk("restart_wr_en", ifc.wr_en, 1);
      chk("restart_addr0", ifc.wr_addr, 0);
      repeat (N-1) step();
      chk("restart_done_ready", ifc.in_ready, 1);
      step();
      drain("drain_restart");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/vga_console.md
# vga_console

Character-stream console controller that drives the write port of the VGA text-mode top (`DATA_ADDR`, `DATA_IN`, `WR_EN`). It accepts bytes over a valid/ready handshake and keeps a cursor. Control codes become cursor moves or clears, and printable bytes become single-cell writes. After reset, and on form feed, it sequences a full-screen clear.

## Interface
- `COLS`, 160: text columns (h_disp / 8).
- `ROWS`, 128: text rows (v_disp / 8).
- `ADDR_WIDTH`, `$clog2(COLS*ROWS)`: width of the cell address (15 at defaults).
- `clk` input 1: single clock, same clock as the text buffer write port.
- `reset` input 1: asynchronous, active-high.
- `in_valid` input 1: input byte valid.
- `in_data` input 8: input byte.
- `in_ready` output 1: byte accepted on an edge where `in_valid & in_ready`.
- `wr_en` output 1: write strobe to buffer (`WR_EN`).
- `wr_addr` output ADDR_WIDTH: cell address, `row*COLS + col` (`DATA_ADDR`).
- `wr_data` output 8: character code (`DATA_IN`).
- `busy` output 1: clear in progress.
- `cursor_col` output `$clog2(COLS)`: current column.
- `cursor_row` output `$clog2(ROWS)`: current row.

## Operation
- Two states: CLEAR and IDLE.
- N = COLS*ROWS. A linear cursor address `cur_addr` is maintained alongside col/row. No multiplier is used.
- Reset (async) values:
  - state = CLEAR, clear counter = 0.
  - cursor col/row/addr = 0.
  - `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `in_ready` = 0, `busy` = 1.
- CLEAR behaviour:
  - Each edge registers `wr_en`=1, `wr_addr`=counter, `wr_data`=0x20, then increments the counter.
  - The edge that writes N-1 moves to IDLE and resets the counter.
  - Cursor holds 0,0.
- IDLE behaviour:
  - `in_ready`=1.
  - Per accepted byte the registered outputs update as follows; an unlisted field holds.
  - 0x20..0x7E (printable):
    - Write `in_data` at `cur_addr`.
    - Advance col.
    - At col COLS-1: col=0, row+1.
    - At row ROWS-1, col COLS-1: wrap to 0,0 (addr 0).
  - 0x0A (LF): col=0, row+1 (row ROWS-1 wraps to 0). No write.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS):
    - If col>0: col-1, then write 0x20 at the new address.
    - If col=0: no move, no write.
  - 0x0C (FF): go to CLEAR, counter=0, cursor=0,0. No write on the accepting edge.
  - Any other byte: consumed, no write, cursor unchanged.
- `wr_en` is 0 on any IDLE edge without an accepted byte. `wr_addr`/`wr_data` hold their last values.
- `in_ready` = (state==IDLE) and `busy` = (state==CLEAR), both decoded combinationally from the registered state.
- Address arithmetic is modulo N, with explicit compares against N-1, COLS-1 and ROWS-1 (no power-of-two reliance).
- Reset asserted mid-clear or mid-stream aborts immediately and restarts the clear from address 0.

## Timing
- Write latency: a byte accepted at edge t produces its `wr_en`/`wr_addr`/`wr_data` from edge t to edge t+1. The cursor outputs reflect the post-byte position from edge t.
- Throughput in IDLE: one byte per cycle, no bubbles.
- Clear after reset deassertion: writes addresses 0..N-1 on edges 1..N. `in_ready` rises after edge N, and `busy` falls there.
- Clear after FF accepted at edge t: writes on edges t+1..t+N. `in_ready` is 0 during (t, t+N] and returns to 1 after edge t+N.
- `in_valid` may be held high during CLEAR; the byte is not consumed until `in_ready`=1. `in_data` must remain stable while `in_valid` is high and unaccepted.

## Test plan
Bench parameters COLS=4, ROWS=2, N=8 unless noted.
- Reset then idle:
  - Edges 1..8 write 0x20 to addresses 0..7 and nothing else.
  - `busy` is 1 then 0, and `in_ready` is 1 after edge 8.
  - Edge 9 has `wr_en`=0.
- Stream 'A','B','C','D','E' back-to-back:
  - Writes (0,0x41),(1,0x42),(2,0x43),(3,0x44),(4,0x45) on consecutive edges.
  - Final cursor col=1, row=1.
- Wrap:
  - Send 8 × 'x' and then 'y'.
  - 'y' writes address 0 and the cursor ends at 1,0.
  - Separately, LF at row 1 returns row to 0 with no write.
- Control codes:
  - 'A','B', BS: BS writes 0x20 at address 1 and the cursor ends at col 1.
  - CR then BS: no write.
  - Bytes 0x07 and 0x7F are consumed with no write.
- FF with `in_valid` held:
  - FF accepted at edge t, then 'Z' presented immediately.
  - Exactly 8 clear writes follow, and `in_ready` stays 0.
  - 'Z' is written to address 0 at edge t+9.
- Reset mid-clear:
  - Assert reset during clear write of address 5.
  - Outputs go to reset values asynchronously.
  - After release the clear restarts at address 0 and runs a full 8 writes.
